// File: rtl/mem_ctrl_pkg.sv
// Shared types and lane constants for the data-memory controller.
// Big-endian: byte offset 0 lives in the most significant lane.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} accSize_t;

  localparam logic [1:0] LANE_MSB   = 2'd3;
  localparam logic [3:0] HALF_HI_BE = 4'b1100;
  localparam logic [3:0] HALF_LO_BE = 4'b0011;
  localparam logic [3:0] WORD_BE    = 4'b1111;

  function automatic logic [1:0] byteLane(input logic [1:0] off);
    return LANE_MSB - off;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for stores and extraction/extension for loads.
// Sub-word stores are replicated across all lanes; byte enables select.
module dmem_lane_align
  import mem_ctrl_pkg::*;
(
  input  accSize_t    size,
  input  logic [1:0]  off,
  input  logic        signExt,
  input  logic [31:0] storeData,
  input  logic [31:0] loadWord,
  output logic [3:0]  byteEn,
  output logic [31:0] storeLanes,
  output logic [31:0] loadData
);

  logic [1:0]  lane;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  always_comb begin
    lane       = byteLane(off);
    loadByte   = loadWord[{lane, 3'b000} +: 8];
    loadHalf   = off[1] ? loadWord[15:0] : loadWord[31:16];
    byteEn     = WORD_BE;
    storeLanes = storeData;
    loadData   = loadWord;
    unique case (size)
      BYTE: begin
        byteEn     = 4'b0001 << lane;
        storeLanes = {4{storeData[7:0]}};
        loadData   = {{24{signExt & loadByte[7]}}, loadByte};
      end
      HALF: begin
        byteEn     = off[1] ? HALF_LO_BE : HALF_HI_BE;
        storeLanes = {2{storeData[15:0]}};
        loadData   = {{16{signExt & loadHalf[15]}}, loadHalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_controller.sv
// MEM-stage data memory controller: request latch, bus FSM and
// LL/SC reservation; lane handling lives in dmem_lane_align.
module dmem_controller
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemHalf,
  input  logic        MemByte,
  input  logic        MemSignExtend,
  input  logic        LLSC,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        Flush,
  output logic        StallController,
  output logic [31:0] MemReadData,
  output logic        AddrErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t      state, nextState;
  accSize_t    size, reqSize, alignSize;
  logic [1:0]  reqOff, alignOff;
  logic        reqSext, reqWe, reqSc, flushPend;
  logic        resValid;
  logic [29:0] resAddr;
  logic        req, isLl, isSc, misaligned, accept, scOk, dropResult;
  logic [3:0]  alignBe;
  logic [31:0] alignWdata, alignLoad;

  always_comb begin
    req  = MemRead | MemWrite;
    isLl = MemRead & ~MemWrite & LLSC;
    isSc = MemWrite & LLSC;
    size = WORD;
    unique case (1'b1)
      isLl | isSc: size = WORD;
      MemByte:     size = BYTE;
      MemHalf:     size = HALF;
      default:     size = WORD;
    endcase
    misaligned = (size == HALF && Addr[0]) ||
                 (size == WORD && Addr[1:0] != 2'b00);
    accept     = (state == IDLE) && req && !Flush && !misaligned;
    scOk       = resValid && (resAddr == Addr[31:2]);
    dropResult = flushPend || Flush;
    AddrErr    = (state == IDLE) && req && !Flush && misaligned;
    StallController = accept || (state == BUSY);
    alignSize  = (state == IDLE) ? size : reqSize;
    alignOff   = (state == IDLE) ? Addr[1:0] : reqOff;
  end

  dmem_lane_align uAlign (
    .size       (alignSize),
    .off        (alignOff),
    .signExt    ((state == IDLE) ? MemSignExtend : reqSext),
    .storeData  (WriteData),
    .loadWord   (bus_rdata),
    .byteEn     (alignBe),
    .storeLanes (alignWdata),
    .loadData   (alignLoad)
  );

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (accept) nextState = (isSc && !scOk) ? DONE : BUSY;
      BUSY: if (bus_ack) nextState = dropResult ? IDLE : DONE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      MemReadData <= '0;
      reqSize     <= WORD;
      reqOff      <= '0;
      reqSext     <= 1'b0;
      reqWe       <= 1'b0;
      reqSc       <= 1'b0;
      flushPend   <= 1'b0;
      resValid    <= 1'b0;
      resAddr     <= '0;
    end else begin
      state     <= nextState;
      flushPend <= (state == BUSY) && !bus_ack && dropResult;
      if (accept) begin
        reqSize <= size;
        reqOff  <= Addr[1:0];
        reqSext <= MemSignExtend;
        reqWe   <= MemWrite;
        reqSc   <= isSc;
      end
      if (accept && nextState == BUSY) begin
        bus_req   <= 1'b1;
        bus_we    <= MemWrite;
        bus_addr  <= {Addr[31:2], 2'b00};
        bus_be    <= MemWrite ? alignBe : WORD_BE;
        bus_wdata <= MemWrite ? alignWdata : '0;
      end else if (state == BUSY && bus_ack) begin
        bus_req <= 1'b0;
        bus_we  <= 1'b0;
      end
      // Failed SC reports 0 without touching the bus
      if (accept && isSc && !scOk)
        MemReadData <= '0;
      else if (state == BUSY && bus_ack && !dropResult)
        MemReadData <= reqSc ? 32'd1 : (reqWe ? '0 : alignLoad);
      if (Flush || (state == IDLE && isSc))
        resValid <= 1'b0;
      else if (accept && isLl) begin
        resValid <= 1'b1;
        resAddr  <= Addr[31:2];
      end
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Directed scoreboard bench for dmem_controller.
// Stimulus queues expected bus and completion events; a monitor checks them.
module tb_dmem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 0, MemWrite = 0, MemHalf = 0, MemByte = 0;
  logic        MemSignExtend = 0, LLSC = 0, Flush = 0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic        StallController, AddrErr;
  logic [31:0] MemReadData;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  dmem_controller dut (
    .clk             (clk),
    .rst             (rst),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .MemHalf         (MemHalf),
    .MemByte         (MemByte),
    .MemSignExtend   (MemSignExtend),
    .LLSC            (LLSC),
    .Addr            (Addr),
    .WriteData       (WriteData),
    .Flush           (Flush),
    .StallController (StallController),
    .MemReadData     (MemReadData),
    .AddrErr         (AddrErr),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_be          (bus_be),
    .bus_wdata       (bus_wdata),
    .bus_ack         (bus_ack),
    .bus_rdata       (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } busExp_t;

  typedef struct {
    int          stalls;
    logic [31:0] data;
  } doneExp_t;

  busExp_t  busQ[$];
  doneExp_t doneQ[$];
  busExp_t  bExp;
  doneExp_t dExp;
  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expBus(input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
    busQ.push_back('{addr: a, we: w, be: b, wdata: d});
  endtask

  task automatic expDone(input int s, input logic [31:0] d);
    doneQ.push_back('{stalls: s, data: d});
  endtask

  logic prevReq = 1'b0;
  logic prevStall = 1'b0;
  int   stallCnt = 0;

  always @(negedge clk) begin
    if (bus_req && !prevReq) begin
      if (busQ.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL busUnexpected: got addr %h want no access", bus_addr);
      end else begin
        bExp = busQ.pop_front();
        check("busAddr", bus_addr, bExp.addr);
        check("busWe", {31'd0, bus_we}, {31'd0, bExp.we});
        check("busBe", {28'd0, bus_be}, {28'd0, bExp.be});
        check("busWdata", bus_wdata, bExp.wdata);
      end
    end
    if (StallController) stallCnt++;
    else if (prevStall) begin
      if (doneQ.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL doneUnexpected: got data %h want none", MemReadData);
      end else begin
        dExp = doneQ.pop_front();
        check("stallCycles", stallCnt, dExp.stalls);
        check("readData", MemReadData, dExp.data);
      end
      stallCnt = 0;
    end
    prevReq   = bus_req;
    prevStall = StallController;
  end

  task automatic clearReq();
    MemRead = 0; MemWrite = 0; MemHalf = 0; MemByte = 0;
    MemSignExtend = 0; LLSC = 0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic hf,
                        input logic by, input logic sx, input logic ls,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int busy, input logic [31:0] rdata,
                        input int flushAt);
    MemRead = rd; MemWrite = wr; MemHalf = hf; MemByte = by;
    MemSignExtend = sx; LLSC = ls; Addr = a; WriteData = wd;
    @(posedge clk); #1;
    clearReq();
    for (int i = 1; i <= busy; i++) begin
      bus_ack   = (i == busy);
      bus_rdata = rdata;
      Flush     = (i == flushAt);
      @(negedge clk);
      check("busReqHeld", {31'd0, bus_req}, 32'd1);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      Flush   = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic misalign(input logic hf, input logic [31:0] a);
    MemRead = 1; MemHalf = hf; Addr = a;
    @(negedge clk);
    check("addrErrPulse", {31'd0, AddrErr}, 32'd1);
    check("addrErrNoStall", {31'd0, StallController}, 32'd0);
    @(posedge clk); #1;
    clearReq();
    @(negedge clk);
    check("addrErrEnd", {31'd0, AddrErr}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstBusReq", {31'd0, bus_req}, 32'd0);
    check("rstBusWe", {31'd0, bus_we}, 32'd0);
    check("rstBusBe", {28'd0, bus_be}, 32'd0);
    check("rstBusAddr", bus_addr, 32'd0);
    check("rstBusWdata", bus_wdata, 32'd0);
    check("rstReadData", MemReadData, 32'd0);
    check("rstAddrErr", {31'd0, AddrErr}, 32'd0);
    check("rstStall", {31'd0, StallController}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    expBus(32'h100, 0, 4'hF, 0); expDone(3, 32'hDEADBEEF);
    access(1, 0, 0, 0, 0, 0, 32'h100, 0, 2, 32'hDEADBEEF, 0);
    expBus(32'h100, 0, 4'hF, 0); expDone(2, 32'hFFFFFFF0);
    access(1, 0, 0, 1, 1, 0, 32'h103, 0, 1, 32'h000000F0, 0);
    expBus(32'h100, 0, 4'hF, 0); expDone(2, 32'h000000F0);
    access(1, 0, 0, 1, 0, 0, 32'h103, 0, 1, 32'h000000F0, 0);
    expBus(32'h100, 0, 4'hF, 0); expDone(2, 32'hFFFF8001);
    access(1, 0, 1, 0, 1, 0, 32'h102, 0, 1, 32'h12348001, 0);
    expBus(32'h100, 0, 4'hF, 0); expDone(2, 32'h00008001);
    access(1, 0, 1, 0, 0, 0, 32'h100, 0, 1, 32'h80017FFF, 0);
    expBus(32'h100, 0, 4'hF, 0); expDone(2, 32'h0000007F);
    access(1, 0, 0, 1, 1, 0, 32'h100, 0, 1, 32'h7F000000, 0);

    expBus(32'h200, 1, 4'b0011, 32'h12341234); expDone(2, 0);
    access(0, 1, 1, 0, 0, 0, 32'h202, 32'h1234, 1, 0, 0);
    expBus(32'h200, 1, 4'b0100, 32'hABABABAB); expDone(2, 0);
    access(0, 1, 0, 1, 0, 0, 32'h201, 32'hABCD00AB, 1, 0, 0);
    expBus(32'h204, 1, 4'hF, 32'hCAFEF00D); expDone(4, 0);
    access(0, 1, 0, 0, 0, 0, 32'h204, 32'hCAFEF00D, 3, 0, 0);
    expBus(32'h208, 1, 4'hF, 32'h0BADF00D); expDone(2, 0);
    access(1, 1, 0, 0, 0, 0, 32'h208, 32'h0BADF00D, 1, 32'h77777777, 0);

    expBus(32'h300, 0, 4'hF, 0); expDone(2, 32'h11111111);
    access(1, 0, 0, 0, 0, 1, 32'h300, 0, 1, 32'h11111111, 0);
    expBus(32'h300, 1, 4'hF, 32'h55); expDone(2, 32'd1);
    access(0, 1, 0, 0, 0, 1, 32'h300, 32'h55, 1, 0, 0);
    expDone(1, 32'd0);
    access(0, 1, 0, 0, 0, 1, 32'h300, 32'h66, 0, 0, 0);

    misalign(0, 32'h101);
    misalign(1, 32'h203);

    expBus(32'h500, 0, 4'hF, 0); expDone(2, 32'h600DF00D);
    access(1, 0, 0, 0, 0, 0, 32'h500, 0, 1, 32'h600DF00D, 0);
    expBus(32'h400, 0, 4'hF, 0); expDone(4, 32'h600DF00D);
    access(1, 0, 0, 0, 0, 0, 32'h400, 0, 3, 32'hBADBAD00, 1);

    expBus(32'h600, 0, 4'hF, 0); expDone(2, 32'h6);
    access(1, 0, 0, 0, 0, 1, 32'h600, 0, 1, 32'h6, 0);
    MemRead = 1; Addr = 32'h600; Flush = 1;
    @(negedge clk);
    check("flushIdleNoStall", {31'd0, StallController}, 32'd0);
    @(posedge clk); #1;
    clearReq(); Flush = 0;
    @(posedge clk); #1;
    expDone(1, 32'd0);
    access(0, 1, 0, 0, 0, 1, 32'h600, 32'h99, 0, 0, 0);

    expBus(32'h700, 0, 4'hF, 0); expDone(2, 32'h7);
    access(1, 0, 0, 0, 0, 1, 32'h700, 0, 1, 32'h7, 0);
    expBus(32'h704, 0, 4'hF, 0); expDone(2, 32'd0);
    MemRead = 1; Addr = 32'h704;
    @(posedge clk); #1;
    clearReq(); rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rstBusyReq", {31'd0, bus_req}, 32'd0);
    check("rstBusyStall", {31'd0, StallController}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("strayAckStall", {31'd0, StallController}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 0;
    @(negedge clk);
    check("strayAckData", MemReadData, 32'd0);
    check("strayAckReq", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    expDone(1, 32'd0);
    access(0, 1, 0, 0, 0, 1, 32'h700, 32'h88, 0, 0, 0);

    repeat (3) @(posedge clk);
    check("busQueueDrained", busQ.size(), 32'd0);
    check("doneQueueDrained", doneQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
